// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared types for the TCP slow-path TX engine
package tcp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_STATE,
        ST_TUPLE_REQ,
        ST_TUPLE_RESP,
        ST_CALC,
        ST_PKT_OUT,
        ST_NEXT,
        ST_WRITEBACK,
        ST_SCHED_UPDATE
    } tcp_tx_burst_state_e;

    localparam int unsigned NUM_RD_CH = 3;

endpackage

// File: rtl/tcp_tx_rd_tracker.sv
// rtl/tcp_tx_rd_tracker.sv - request/response completion tracker for one state-read channel
module tcp_tx_rd_tracker (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic req_val,
    input  logic req_rdy,
    input  logic resp_val,
    output logic resp_rdy,
    output logic store,
    output logic done
);

    logic req_done_q, req_done_d;
    logic resp_done_q, resp_done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_done_q  <= 1'b0;
            resp_done_q <= 1'b0;
        end else begin
            req_done_q  <= req_done_d;
            resp_done_q <= resp_done_d;
        end
    end

    // resp_rdy waits on the registered req_done, so a response never lands with its own request
    always_comb begin
        req_val     = en & ~req_done_q;
        resp_rdy    = en & req_done_q & ~resp_done_q;
        store       = resp_val & resp_rdy;
        done        = resp_done_q | store;
        req_done_d  = req_done_q | (req_val & req_rdy);
        resp_done_d = resp_done_q | store;
        if (start) begin
            req_done_d  = 1'b0;
            resp_done_d = 1'b0;
        end
    end

endmodule

// File: rtl/tcp_tx_burst_ctrl.sv
// rtl/tcp_tx_burst_ctrl.sv - per-grant burst control FSM of the TCP slow-path TX engine
module tcp_tx_burst_ctrl
    import tcp_pkg::*;
#(
    parameter int FLOWID_W  = 8,
    parameter int MAX_BURST = 4,
    parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sched_tx_req_val,
    output logic                sched_tx_req_rdy,
    input  logic [FLOWID_W-1:0] sched_tx_req_flowid,
    output logic                sched_tx_update_val,
    input  logic                sched_tx_update_rdy,
    output logic [FLOWID_W-1:0] sched_tx_update_flowid,
    output logic                sched_tx_update_more,
    output logic [BURST_W-1:0]  sched_tx_update_pkts,
    output logic                curr_tx_state_rd_req_val,
    input  logic                curr_tx_state_rd_req_rdy,
    input  logic                curr_tx_state_rd_resp_val,
    output logic                curr_tx_state_rd_resp_rdy,
    output logic                rx_state_rd_req_val,
    input  logic                rx_state_rd_req_rdy,
    input  logic                rx_state_rd_resp_val,
    output logic                rx_state_rd_resp_rdy,
    output logic                tail_ptr_rd_req_val,
    input  logic                tail_ptr_rd_req_rdy,
    input  logic                tail_ptr_rd_resp_val,
    output logic                tail_ptr_rd_resp_rdy,
    output logic                tuple_rd_req_val,
    input  logic                tuple_rd_req_rdy,
    input  logic                tuple_rd_resp_val,
    output logic                tuple_rd_resp_rdy,
    output logic [FLOWID_W-1:0] rd_req_flowid,
    output logic                next_tx_state_wr_req_val,
    input  logic                next_tx_state_wr_req_rdy,
    output logic                ctrl_datap_store_curr,
    output logic                ctrl_datap_store_rx,
    output logic                ctrl_datap_store_tail,
    output logic                ctrl_datap_store_tuple,
    output logic                ctrl_datap_store_calc,
    output logic                ctrl_datap_adv,
    input  logic                datap_ctrl_produce_pkt,
    input  logic                datap_ctrl_more_pkt,
    output logic                tx_pkt_val,
    input  logic                tx_pkt_rdy,
    output logic [31:0]         stat_pkts_sent,
    output logic                busy
);

    tcp_tx_burst_state_e state_q, state_d;
    logic [FLOWID_W-1:0]  flowid_q, flowid_d;
    logic [BURST_W-1:0]   count_q, count_d;
    logic                 sent_q, sent_d;
    logic                 more_q, more_d;
    logic                 more_out_q, more_out_d;
    logic [31:0]          stat_q, stat_d;
    logic                 start, rd_en;
    logic [NUM_RD_CH-1:0] ch_done;

    // decoded from state rather than sched_tx_req_rdy to keep the trackers out of a comb loop
    assign start = (state_q == ST_IDLE) & sched_tx_req_val;
    assign rd_en = (state_q == ST_RD_STATE);

    tcp_tx_rd_tracker u_trk_curr (
        .clk(clk), .rst(rst), .start(start), .en(rd_en),
        .req_val(curr_tx_state_rd_req_val), .req_rdy(curr_tx_state_rd_req_rdy),
        .resp_val(curr_tx_state_rd_resp_val), .resp_rdy(curr_tx_state_rd_resp_rdy),
        .store(ctrl_datap_store_curr), .done(ch_done[0])
    );

    tcp_tx_rd_tracker u_trk_rx (
        .clk(clk), .rst(rst), .start(start), .en(rd_en),
        .req_val(rx_state_rd_req_val), .req_rdy(rx_state_rd_req_rdy),
        .resp_val(rx_state_rd_resp_val), .resp_rdy(rx_state_rd_resp_rdy),
        .store(ctrl_datap_store_rx), .done(ch_done[1])
    );

    tcp_tx_rd_tracker u_trk_tail (
        .clk(clk), .rst(rst), .start(start), .en(rd_en),
        .req_val(tail_ptr_rd_req_val), .req_rdy(tail_ptr_rd_req_rdy),
        .resp_val(tail_ptr_rd_resp_val), .resp_rdy(tail_ptr_rd_resp_rdy),
        .store(ctrl_datap_store_tail), .done(ch_done[2])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            flowid_q   <= '0;
            count_q    <= '0;
            sent_q     <= 1'b0;
            more_q     <= 1'b0;
            more_out_q <= 1'b0;
            stat_q     <= '0;
        end else begin
            state_q    <= state_d;
            flowid_q   <= flowid_d;
            count_q    <= count_d;
            sent_q     <= sent_d;
            more_q     <= more_d;
            more_out_q <= more_out_d;
            stat_q     <= stat_d;
        end
    end

    always_comb begin
        state_d                  = state_q;
        flowid_d                 = flowid_q;
        count_d                  = count_q;
        sent_d                   = sent_q;
        more_d                   = more_q;
        more_out_d               = more_out_q;
        stat_d                   = stat_q;
        sched_tx_req_rdy         = 1'b0;
        sched_tx_update_val      = 1'b0;
        tuple_rd_req_val         = 1'b0;
        tuple_rd_resp_rdy        = 1'b0;
        next_tx_state_wr_req_val = 1'b0;
        ctrl_datap_store_calc    = 1'b0;
        ctrl_datap_adv           = 1'b0;
        tx_pkt_val               = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sched_tx_req_rdy = 1'b1;
                if (sched_tx_req_val) begin
                    flowid_d   = sched_tx_req_flowid;
                    count_d    = '0;
                    sent_d     = 1'b0;
                    more_d     = 1'b0;
                    more_out_d = 1'b0;
                    state_d    = ST_RD_STATE;
                end
            end
            ST_RD_STATE: begin
                if (&ch_done) state_d = ST_TUPLE_REQ;
            end
            ST_TUPLE_REQ: begin
                tuple_rd_req_val = 1'b1;
                if (tuple_rd_req_rdy) state_d = ST_TUPLE_RESP;
            end
            ST_TUPLE_RESP: begin
                tuple_rd_resp_rdy = 1'b1;
                if (tuple_rd_resp_val) state_d = ST_CALC;
            end
            ST_CALC: begin
                ctrl_datap_store_calc = 1'b1;
                state_d               = ST_PKT_OUT;
            end
            ST_PKT_OUT: begin
                tx_pkt_val = datap_ctrl_produce_pkt;
                if (!datap_ctrl_produce_pkt) begin
                    sent_d  = 1'b0;
                    state_d = ST_NEXT;
                end else if (tx_pkt_rdy) begin
                    count_d        = count_q + 1'b1;
                    stat_d         = stat_q + 32'd1;
                    ctrl_datap_adv = 1'b1;
                    more_d         = datap_ctrl_more_pkt;
                    sent_d         = 1'b1;
                    state_d        = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // a capped burst still reports more so the scheduler regrants the flow
                more_out_d = sent_q & more_q;
                if (sent_q && more_q && (count_q < BURST_W'(MAX_BURST))) state_d = ST_CALC;
                else                                                    state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                next_tx_state_wr_req_val = 1'b1;
                if (next_tx_state_wr_req_rdy) state_d = ST_SCHED_UPDATE;
            end
            ST_SCHED_UPDATE: begin
                sched_tx_update_val = 1'b1;
                if (sched_tx_update_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ctrl_datap_store_tuple = tuple_rd_resp_val & tuple_rd_resp_rdy;
    assign rd_req_flowid          = flowid_q;
    assign sched_tx_update_flowid = flowid_q;
    assign sched_tx_update_more   = more_out_q;
    assign sched_tx_update_pkts   = count_q;
    assign stat_pkts_sent         = stat_q;
    assign busy                   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tcp_tx_burst_ctrl.sv
// tb/tb_tcp_tx_burst_ctrl.sv - directed self-checking bench for tcp_tx_burst_ctrl
module tb_tcp_tx_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        sched_tx_req_val = 1'b0;
    logic        sched_tx_req_rdy;
    logic [7:0]  sched_tx_req_flowid = '0;
    logic        sched_tx_update_val;
    logic        sched_tx_update_rdy = 1'b0;
    logic [7:0]  sched_tx_update_flowid;
    logic        sched_tx_update_more;
    logic [2:0]  sched_tx_update_pkts;
    logic [2:0]  m_req_val, m_resp_rdy, m_store;
    logic [2:0]  m_req_rdy = '0;
    logic [2:0]  m_resp_val = '0;
    logic        tuple_rd_req_val, tuple_rd_resp_rdy;
    logic        tuple_rd_req_rdy = 1'b1;
    logic        tuple_rd_resp_val = 1'b1;
    logic [7:0]  rd_req_flowid;
    logic        next_tx_state_wr_req_val;
    logic        next_tx_state_wr_req_rdy = 1'b1;
    logic        ctrl_datap_store_tuple, ctrl_datap_store_calc, ctrl_datap_adv;
    logic        datap_ctrl_produce_pkt = 1'b0;
    logic        datap_ctrl_more_pkt = 1'b0;
    logic        tx_pkt_val;
    logic        tx_pkt_rdy = 1'b0;
    logic [31:0] stat_pkts_sent;
    logic        busy;

    tcp_tx_burst_ctrl #(.FLOWID_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .sched_tx_req_val(sched_tx_req_val), .sched_tx_req_rdy(sched_tx_req_rdy),
        .sched_tx_req_flowid(sched_tx_req_flowid),
        .sched_tx_update_val(sched_tx_update_val), .sched_tx_update_rdy(sched_tx_update_rdy),
        .sched_tx_update_flowid(sched_tx_update_flowid), .sched_tx_update_more(sched_tx_update_more),
        .sched_tx_update_pkts(sched_tx_update_pkts),
        .curr_tx_state_rd_req_val(m_req_val[0]), .curr_tx_state_rd_req_rdy(m_req_rdy[0]),
        .curr_tx_state_rd_resp_val(m_resp_val[0]), .curr_tx_state_rd_resp_rdy(m_resp_rdy[0]),
        .rx_state_rd_req_val(m_req_val[1]), .rx_state_rd_req_rdy(m_req_rdy[1]),
        .rx_state_rd_resp_val(m_resp_val[1]), .rx_state_rd_resp_rdy(m_resp_rdy[1]),
        .tail_ptr_rd_req_val(m_req_val[2]), .tail_ptr_rd_req_rdy(m_req_rdy[2]),
        .tail_ptr_rd_resp_val(m_resp_val[2]), .tail_ptr_rd_resp_rdy(m_resp_rdy[2]),
        .tuple_rd_req_val(tuple_rd_req_val), .tuple_rd_req_rdy(tuple_rd_req_rdy),
        .tuple_rd_resp_val(tuple_rd_resp_val), .tuple_rd_resp_rdy(tuple_rd_resp_rdy),
        .rd_req_flowid(rd_req_flowid),
        .next_tx_state_wr_req_val(next_tx_state_wr_req_val),
        .next_tx_state_wr_req_rdy(next_tx_state_wr_req_rdy),
        .ctrl_datap_store_curr(m_store[0]), .ctrl_datap_store_rx(m_store[1]),
        .ctrl_datap_store_tail(m_store[2]), .ctrl_datap_store_tuple(ctrl_datap_store_tuple),
        .ctrl_datap_store_calc(ctrl_datap_store_calc), .ctrl_datap_adv(ctrl_datap_adv),
        .datap_ctrl_produce_pkt(datap_ctrl_produce_pkt), .datap_ctrl_more_pkt(datap_ctrl_more_pkt),
        .tx_pkt_val(tx_pkt_val), .tx_pkt_rdy(tx_pkt_rdy),
        .stat_pkts_sent(stat_pkts_sent), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // memory channel models and event counters
    int req_dly[3] = '{0, 0, 0};
    int resp_dly[3] = '{0, 0, 0};
    int rc[3] = '{0, 0, 0};
    int sc[3] = '{0, 0, 0};
    bit pend[3] = '{0, 0, 0};
    int req_xfer[3], store_cnt[3];
    int cyc = 0, last_store_cyc, first_tuple_cyc;
    int tx_val_cnt, tx_xfer, adv_cnt, tuple_xfer, wb_xfer, upd_xfer, viol;
    int pkt_stall = 0, pkt_stall_cnt = 0, upd_stall = 0, upd_stall_cnt = 0;
    bit pkt_rdy_en = 1'b1;
    bit prev_pkt_hold = 1'b0, prev_upd_hold = 1'b0;
    logic [11:0] prev_upd = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin pend[c] = 0; rc[c] = 0; sc[c] = 0; end
            pkt_stall_cnt = 0; upd_stall_cnt = 0;
            prev_pkt_hold = 0; prev_upd_hold = 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (m_req_val[c] && m_req_rdy[c]) begin req_xfer[c]++; pend[c] = 1; rc[c] = 0; end
                if (m_resp_val[c] && m_resp_rdy[c]) begin pend[c] = 0; sc[c] = 0; end
                if (m_store[c]) begin store_cnt[c]++; last_store_cyc = cyc; end
            end
            if (tx_pkt_val) begin
                tx_val_cnt++;
                if (tx_pkt_rdy) begin tx_xfer++; pkt_stall_cnt = 0; pkt_stall = 0; end
                else pkt_stall_cnt++;
            end
            if (ctrl_datap_adv) adv_cnt++;
            if (tuple_rd_req_val && tuple_rd_req_rdy) tuple_xfer++;
            if (tuple_rd_req_val && first_tuple_cyc < 0) first_tuple_cyc = cyc;
            if (next_tx_state_wr_req_val && next_tx_state_wr_req_rdy) wb_xfer++;
            if (sched_tx_update_val) begin
                if (sched_tx_update_rdy) begin upd_xfer++; upd_stall_cnt = 0; upd_stall = 0; end
                else upd_stall_cnt++;
            end
            if (prev_pkt_hold && !tx_pkt_val) viol++;
            if (prev_upd_hold && (!sched_tx_update_val ||
                {sched_tx_update_flowid, sched_tx_update_more, sched_tx_update_pkts} != prev_upd)) viol++;
            prev_pkt_hold = tx_pkt_val && !tx_pkt_rdy;
            prev_upd_hold = sched_tx_update_val && !sched_tx_update_rdy;
            prev_upd      = {sched_tx_update_flowid, sched_tx_update_more, sched_tx_update_pkts};
        end
    end

    always begin
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            if (m_req_val[c] && !pend[c]) begin
                m_req_rdy[c] = (rc[c] >= req_dly[c]);
                if (!m_req_rdy[c]) rc[c]++;
            end else m_req_rdy[c] = 1'b0;
            if (pend[c]) begin
                m_resp_val[c] = (sc[c] >= resp_dly[c]);
                if (!m_resp_val[c]) sc[c]++;
            end else m_resp_val[c] = 1'b0;
        end
        tx_pkt_rdy          = pkt_rdy_en && (pkt_stall_cnt >= pkt_stall);
        sched_tx_update_rdy = (upd_stall_cnt >= upd_stall);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 3; c++) begin req_xfer[c] = 0; store_cnt[c] = 0; end
        tx_val_cnt = 0; tx_xfer = 0; adv_cnt = 0; tuple_xfer = 0; wb_xfer = 0;
        upd_xfer = 0; viol = 0; last_store_cyc = -1; first_tuple_cyc = -1;
    endtask

    // call at posedge+1 with the FSM idle; returns at posedge+1 after the update transfer
    task automatic run_grant(input logic [7:0] fid, output int lat,
                             output logic [7:0] uf, output logic [2:0] up, output logic um);
        lat = -1; uf = 'x; up = 'x; um = 1'bx;
        sched_tx_req_flowid = fid;
        sched_tx_req_val    = 1'b1;
        @(negedge clk);
        chk("grant_rdy", {31'd0, sched_tx_req_rdy}, 32'd1);
        @(posedge clk); #1;
        sched_tx_req_val = 1'b0;
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            if (sched_tx_update_val && sched_tx_update_rdy) begin
                lat = i; uf = sched_tx_update_flowid; up = sched_tx_update_pkts; um = sched_tx_update_more;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    int lat;
    logic [7:0] uf;
    logic [2:0] up;
    logic um;
    int seen;

    initial begin
        clear_counts();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_rdy", {31'd0, sched_tx_req_rdy}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_vals", {22'd0, m_req_val, m_resp_rdy, tuple_rd_req_val, tuple_rd_resp_rdy,
                         next_tx_state_wr_req_val, sched_tx_update_val}, 32'd0);
        chk("rst_strobes", {24'd0, m_store, ctrl_datap_store_tuple, ctrl_datap_store_calc,
                            ctrl_datap_adv, tx_pkt_val, 1'b0}, 32'd0);
        chk("rst_update_fields", {20'd0, sched_tx_update_flowid, sched_tx_update_more,
                                  sched_tx_update_pkts}, 32'd0);
        chk("rst_stat", stat_pkts_sent, 32'd0);
        @(posedge clk); #1;

        // single packet, everything ready
        clear_counts();
        datap_ctrl_produce_pkt = 1'b1; datap_ctrl_more_pkt = 1'b0;
        run_grant(8'h11, lat, uf, up, um);
        chk("t1_latency", lat, 32'd9);
        chk("t1_flowid", {24'd0, uf}, 32'h11);
        chk("t1_pkts", {29'd0, up}, 32'd1);
        chk("t1_more", {31'd0, um}, 32'd0);
        chk("t1_stat", stat_pkts_sent, 32'd1);
        chk("t1_tx_xfer", tx_xfer, 32'd1);
        chk("t1_tuple_wb", {tuple_xfer[15:0], wb_xfer[15:0]}, 32'h0001_0001);

        // skewed handshakes: tail request held off 5 cycles, curr response 3 cycles after rx
        clear_counts();
        req_dly[2] = 5; resp_dly[0] = 3;
        run_grant(8'h22, lat, uf, up, um);
        req_dly[2] = 0; resp_dly[0] = 0;
        chk("t2_latency", lat, 32'd14);
        chk("t2_stores", {8'd0, store_cnt[0][7:0], store_cnt[1][7:0], store_cnt[2][7:0]}, 32'h0001_0101);
        chk("t2_req_xfers", {8'd0, req_xfer[0][7:0], req_xfer[1][7:0], req_xfer[2][7:0]}, 32'h0001_0101);
        chk("t2_tuple_gap", first_tuple_cyc - last_store_cyc, 32'd1);
        chk("t2_flowid", {24'd0, uf}, 32'h22);
        chk("t2_stat", stat_pkts_sent, 32'd2);

        // burst capped at MAX_BURST
        clear_counts();
        datap_ctrl_more_pkt = 1'b1;
        run_grant(8'h33, lat, uf, up, um);
        chk("t3_latency", lat, 32'd18);
        chk("t3_pkts", {29'd0, up}, 32'd4);
        chk("t3_more", {31'd0, um}, 32'd1);
        chk("t3_tx_xfer", tx_xfer, 32'd4);
        chk("t3_adv", adv_cnt, 32'd4);
        chk("t3_tuple", tuple_xfer, 32'd1);
        chk("t3_wb", wb_xfer, 32'd1);
        chk("t3_stat", stat_pkts_sent, 32'd6);

        // nothing to send
        clear_counts();
        datap_ctrl_produce_pkt = 1'b0; datap_ctrl_more_pkt = 1'b1;
        run_grant(8'h44, lat, uf, up, um);
        chk("t4_latency", lat, 32'd9);
        chk("t4_tx_val", tx_val_cnt, 32'd0);
        chk("t4_wb", wb_xfer, 32'd1);
        chk("t4_pkts_more", {28'd0, up, um}, 32'd0);
        chk("t4_stat", stat_pkts_sent, 32'd6);

        // backpressure on packet and update
        clear_counts();
        datap_ctrl_produce_pkt = 1'b1; datap_ctrl_more_pkt = 1'b0;
        pkt_stall = 10; upd_stall = 7;
        run_grant(8'h55, lat, uf, up, um);
        chk("t5_latency", lat, 32'd26);
        chk("t5_tx_xfer", tx_xfer, 32'd1);
        chk("t5_stable", viol, 32'd0);
        chk("t5_fields", {20'd0, uf, um, up}, {20'd0, 8'h55, 1'b0, 3'd1});
        chk("t5_stat", stat_pkts_sent, 32'd7);

        // reset while the second burst packet is pending
        clear_counts();
        datap_ctrl_more_pkt = 1'b1;
        sched_tx_req_flowid = 8'h66; sched_tx_req_val = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        sched_tx_req_val = 1'b0;
        for (int i = 0; i < 100 && tx_xfer < 1; i++) @(negedge clk);
        @(posedge clk); #1;
        pkt_rdy_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_pkt_val) begin seen = 1; break; end
        end
        chk("t6_second_pkt_pending", seen, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_idle", {30'd0, busy, sched_tx_req_rdy}, 32'd1);
        chk("t6_outputs", {24'd0, m_req_val, tx_pkt_val, sched_tx_update_val,
                           next_tx_state_wr_req_val, tuple_rd_req_val, ctrl_datap_adv}, 32'd0);
        chk("t6_stat", stat_pkts_sent, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; pkt_rdy_en = 1'b1;
        chk("t6_no_wb_upd", {wb_xfer[15:0], upd_xfer[15:0]}, 32'd0);
        chk("t6_one_pkt", tx_xfer, 32'd1);
        datap_ctrl_more_pkt = 1'b0;
        run_grant(8'h5A, lat, uf, up, um);
        chk("t6_new_latency", lat, 32'd9);
        chk("t6_new_fields", {20'd0, uf, um, up}, {20'd0, 8'h5A, 1'b0, 3'd1});
        chk("t6_new_stat", stat_pkts_sent, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
